// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shift unit: op encodings, op
// legality check, and the rule that spreads the shift mux levels over the stages.
package shift_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        OP_ROL  = 3'd0,
        OP_ROR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SHRA = 3'd4
    } shift_op_e;

    function automatic logic is_legal_op(input logic [SHIFT_OP_W-1:0] op);
        return op <= OP_SHRA;
    endfunction

    // Earlier stages take the extra level when the levels do not divide evenly.
    function automatic int stage_num_lvl(input int shw, input int stages, input int k);
        return (shw / stages) + ((k < (shw % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_first_lvl(input int shw, input int stages, input int k);
        return k * (shw / stages) + ((k < (shw % stages)) ? k : (shw % stages));
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice of the barrel shift unit: mux levels FIRST_LVL..FIRST_LVL+NUM_LVL-1
// plus a valid/ready register. Carry/zero flags exist only when SHIFT_FLAGS_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic                     ready_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    input  logic [SHIFT_OP_W-1:0]    op_i,
    input  logic                     fill_i,
`ifdef SHIFT_FLAGS_EN
    input  logic                     carry_i,
    output logic                     carry_o,
    output logic                     zero_o,
`endif
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(WIDTH)-1:0] amt_o,
    output logic [SHIFT_OP_W-1:0]    op_o,
    output logic                     fill_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic                  valid_q;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [SHW-1:0]        amt_q;
    logic [SHIFT_OP_W-1:0] op_q;
    logic                  fill_q;
    logic                  accept;
    int                    shamt;

    // Illegal ops arrive with zeroed data, so passing them through keeps them zero.
    always_comb begin
        data_d = data_i;
        shamt  = 0;
        for (int l = 0; l < NUM_LVL; l++) begin
            shamt = 1 << (FIRST_LVL + l);
            if (amt_i[FIRST_LVL + l]) begin
                case (op_i)
                    OP_ROL:  data_d = (data_d << shamt) | (data_d >> (WIDTH - shamt));
                    OP_ROR:  data_d = (data_d >> shamt) | (data_d << (WIDTH - shamt));
                    OP_SHL:  data_d = data_d << shamt;
                    OP_SHR:  data_d = data_d >> shamt;
                    OP_SHRA: data_d = (data_d >> shamt) | (fill_i ? ~(ONES >> shamt) : '0);
                    default: data_d = data_d;
                endcase
            end
        end
    end

    assign accept = valid_i & (~valid_q | ready_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= '0;
            fill_q  <= 1'b0;
        end else begin
            if (!valid_q || ready_i) begin
                valid_q <= valid_i;
            end
            if (accept) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                op_q   <= op_i;
                fill_q <= fill_i;
            end
        end
    end

`ifdef SHIFT_FLAGS_EN
    logic carry_q, zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            carry_q <= carry_i;
            zero_q  <= (data_d == '0);
        end
    end

    assign carry_o = carry_q;
    assign zero_o  = zero_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign op_o    = op_q;
    assign fill_o  = fill_q;

endmodule

// File: rtl/barrel_shift_unit.sv
// Pipelined shift/rotate unit (ROL, ROR, SHL, SHR, SHRA), PIPE_STAGES cycles latency.
// Define SHIFT_FLAGS_EN to add the registered out_carry/out_zero flag outputs.
module barrel_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHIFT_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
`ifdef SHIFT_FLAGS_EN
    output logic                  out_carry,
    output logic                  out_zero,
`endif
    output logic                  out_illegal
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: a transfer happens on any edge where valid && ready. A stage is
    // ready when empty or when its successor is ready, so a full pipe still
    // advances every stage in one cycle while the consumer drains.
    logic                  valid_c [0:PIPE_STAGES];
    logic                  ready_c [0:PIPE_STAGES-1];
    logic [WIDTH-1:0]      data_c  [0:PIPE_STAGES];
    logic [SHW-1:0]        amt_c   [0:PIPE_STAGES];
    logic [SHIFT_OP_W-1:0] op_c    [0:PIPE_STAGES];
    logic                  fill_c  [0:PIPE_STAGES];
    logic                  rdy_chain;
    logic                  legal;
    logic [SHW-1:0]        n;
    logic                  unused_tail;

    assign n     = in_b[SHW-1:0];
    assign legal = is_legal_op(in_op);

    assign valid_c[0] = in_valid;
    assign data_c[0]  = legal ? in_a : '0;
    assign amt_c[0]   = n;
    assign op_c[0]    = in_op;
    assign fill_c[0]  = (in_op == OP_SHRA) & in_a[WIDTH-1];

    always_comb begin
        rdy_chain = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            ready_c[k] = rdy_chain;
            rdy_chain  = ~valid_c[k+1] | rdy_chain;
        end
    end

    assign in_ready = rdy_chain;

`ifdef SHIFT_FLAGS_EN
    logic           carry_c [0:PIPE_STAGES];
    logic           zero_c  [0:PIPE_STAGES-1];
    logic [SHW-1:0] idx_left, idx_right;
    logic           unused_zero;

    // WIDTH is a power of two, so -n wraps to WIDTH-n for n > 0.
    assign idx_left  = -n;
    assign idx_right = n - SHW'(1);
    assign carry_c[0] = legal && (n != '0) &&
                        (((in_op == OP_ROL) || (in_op == OP_SHL)) ? in_a[idx_left]
                                                                  : in_a[idx_right]);

    always_comb begin
        unused_zero = 1'b0;
        for (int k = 0; k < PIPE_STAGES - 1; k++) begin
            unused_zero = unused_zero ^ zero_c[k];
        end
    end

    assign out_carry = carry_c[PIPE_STAGES];
    assign out_zero  = zero_c[PIPE_STAGES-1];
`endif

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH     (WIDTH),
            .FIRST_LVL (stage_first_lvl(SHW, PIPE_STAGES, k)),
            .NUM_LVL   (stage_num_lvl(SHW, PIPE_STAGES, k))
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .valid_i (valid_c[k]),
            .ready_i (ready_c[k]),
            .data_i  (data_c[k]),
            .amt_i   (amt_c[k]),
            .op_i    (op_c[k]),
            .fill_i  (fill_c[k]),
`ifdef SHIFT_FLAGS_EN
            .carry_i (carry_c[k]),
            .carry_o (carry_c[k+1]),
            .zero_o  (zero_c[k]),
`endif
            .valid_o (valid_c[k+1]),
            .data_o  (data_c[k+1]),
            .amt_o   (amt_c[k+1]),
            .op_o    (op_c[k+1]),
            .fill_o  (fill_c[k+1])
        );
    end

    assign out_valid   = valid_c[PIPE_STAGES];
    assign out_result  = data_c[PIPE_STAGES];
    assign out_illegal = ~is_legal_op(op_c[PIPE_STAGES]);

    assign unused_tail = ^{in_b[WIDTH-1:SHW], amt_c[PIPE_STAGES], fill_c[PIPE_STAGES]};

endmodule

// File: tb/tb_barrel_shift_unit.sv
// Directed bench for barrel_shift_unit (WIDTH=32, PIPE_STAGES=2); flag checks
// are compiled in when SHIFT_FLAGS_EN is defined.
module tb_barrel_shift_unit;
    import shift_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   in_op = 3'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_illegal;
`ifdef SHIFT_FLAGS_EN
    logic         out_carry;
    logic         out_zero;
`endif

    barrel_shift_unit #(.WIDTH(W), .PIPE_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
`ifdef SHIFT_FLAGS_EN
        .out_carry   (out_carry),
        .out_zero    (out_zero),
`endif
        .out_illegal (out_illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
        logic         car;
        logic         zer;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        logic         car;
        logic         zer;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vec_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every completed transfer must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            check_eq("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("result", out_result, e.res);
                check_eq("illegal", out_illegal, e.ill);
`ifdef SHIFT_FLAGS_EN
                check_eq("carry", out_carry, e.car);
                check_eq("zero", out_zero, e.zer);
`endif
                if (e.lat) check_eq("latency", cyc - e.acc, 2);
            end
        end
    end

    // drivers
    task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic ill, input logic car,
                           input logic zer);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.ill = ill; v.car = car; v.zer = zer;
        vec_q.push_back(v);
    endtask

    task automatic send(input vec_t v, input bit track, input bit lat);
        exp_t e;
        bit   accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            check_eq("in_ready_timeout", in_ready, 1);
        end else if (track) begin
            e.res = v.res; e.ill = v.ill; e.car = v.car; e.zer = v.zer;
            e.acc = cyc;   e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_vecs();
        while (vec_q.size() != 0) send(vec_q.pop_front(), 1'b1, 1'b1);
        idle();
        wait_drain();
    endtask

    int   acc_n;
    vec_t stall_v [0:2];

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_illegal", out_illegal, 0);
        check_eq("rst_in_ready", in_ready, 1);
`ifdef SHIFT_FLAGS_EN
        check_eq("rst_out_carry", out_carry, 0);
        check_eq("rst_out_zero", out_zero, 0);
`endif
        @(posedge clk);
        #1;

        // single ops with latency check
        add_vec(OP_ROL, 32'h8000_0001, 32'd1, 32'h0000_0003, 0, 1, 0);
        run_vecs();
        add_vec(OP_ROR, 32'h0000_0001, 32'd4, 32'h1000_0000, 0, 0, 0);
        run_vecs();

        // shift extremes, modulo amount, zero amount, illegal ops
        add_vec(OP_SHRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 0, 0);
        add_vec(OP_SHR,  32'h8000_0000, 32'd31, 32'h0000_0001, 0, 0, 0);
        add_vec(OP_SHL,  32'h0000_0001, 32'd31, 32'h8000_0000, 0, 0, 0);
        add_vec(OP_SHL,  32'h8000_0000, 32'd1,  32'h0000_0000, 0, 1, 1);
        add_vec(OP_ROL,  32'h0000_0001, 32'd33, 32'h0000_0002, 0, 0, 0);
        for (int op = 0; op < 5; op++)
            add_vec(3'(op), 32'hA5A5_0F0F, 32'd0, 32'hA5A5_0F0F, 0, 0, 0);
        add_vec(3'd6, 32'h1234_5678, 32'd3, 32'h0, 1, 0, 1);
        add_vec(3'd5, 32'hFFFF_FFFF, 32'd0, 32'h0, 1, 0, 1);
        add_vec(OP_ROR,  32'h0000_00F1, 32'd8,  32'hF100_0000, 0, 1, 0);
        add_vec(OP_SHR,  32'h0000_00F0, 32'd4,  32'h0000_000F, 0, 0, 0);
        add_vec(OP_SHRA, 32'h7000_0000, 32'd4,  32'h0700_0000, 0, 0, 0);
        add_vec(OP_SHL,  32'h0000_0005, 32'd32, 32'h0000_0005, 0, 0, 0);
        run_vecs();

        // back-to-back: latency 2 on each means 8 consecutive results
        add_vec(OP_ROL,  32'h1234_5678, 32'd4,  32'h2345_6781, 0, 1, 0);
        add_vec(OP_ROR,  32'h1234_5678, 32'd4,  32'h8123_4567, 0, 1, 0);
        add_vec(OP_SHL,  32'h1234_5678, 32'd8,  32'h3456_7800, 0, 0, 0);
        add_vec(OP_SHR,  32'h1234_5678, 32'd8,  32'h0012_3456, 0, 0, 0);
        add_vec(OP_SHRA, 32'hF234_5678, 32'd8,  32'hFFF2_3456, 0, 0, 0);
        add_vec(OP_SHRA, 32'hF234_5678, 32'd16, 32'hFFFF_F234, 0, 0, 0);
        add_vec(OP_SHL,  32'h0000_FFFF, 32'd16, 32'hFFFF_0000, 0, 0, 0);
        add_vec(OP_SHR,  32'h0000_FFFF, 32'd1,  32'h0000_7FFF, 0, 1, 0);
        run_vecs();

        // stall: consumer blocked for 5 cycles with input always offered
        stall_v[0] = '{op: OP_SHL, a: 32'h3, b: 32'd2, res: 32'hC, ill: 0, car: 0, zer: 0};
        stall_v[1] = '{op: OP_SHR, a: 32'hC, b: 32'd2, res: 32'h3, ill: 0, car: 0, zer: 0};
        stall_v[2] = '{op: OP_ROL, a: 32'h1, b: 32'd1, res: 32'h2, ill: 0, car: 0, zer: 0};
        out_ready = 1'b0;
        acc_n     = 0;
        in_valid  = 1'b1;
        in_op = stall_v[0].op; in_a = stall_v[0].a; in_b = stall_v[0].b;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) check_eq("stall_hold", out_result, stall_v[0].res);
            if (in_ready) begin
                exp_q.push_back('{res: stall_v[acc_n].res, ill: stall_v[acc_n].ill,
                                  car: stall_v[acc_n].car, zer: stall_v[acc_n].zer,
                                  acc: cyc, lat: 1'b0});
                acc_n++;
            end
            @(posedge clk);
            #1;
            in_op = stall_v[acc_n].op; in_a = stall_v[acc_n].a; in_b = stall_v[acc_n].b;
        end
        @(negedge clk);
        check_eq("stall_accepts", acc_n, 2);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        check_eq("stall_result", out_result, stall_v[0].res);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // reset with two ops in flight: neither may emerge
        send(stall_v[2], 1'b0, 1'b0);
        send(stall_v[0], 1'b0, 1'b0);
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        check_eq("flush_out_result", out_result, 0);
        @(posedge clk);
        #1;
        add_vec(OP_SHR, 32'h0000_0100, 32'd8, 32'h0000_0001, 0, 0, 0);
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
